// File: rtl/loop_seq_pkg.sv
// loop_seq_pkg
//   Shared types and defaults for the two-level loop sequencer.
//   - state_t : sequencer state encoding
//   - outs_t  : bundle of Moore outputs decoded from a state
//   - decode(): state -> output bundle
package loop_seq_pkg;

    localparam int SETTLE_DEF = 1;
    localparam int ITW_DEF    = 16;

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        WAIT,
        CHK_I,
        CHK_J,
        BODY_GO,
        BODY_WAIT,
        INC_J,
        INC_I,
        FIN
    } state_t;

    typedef struct packed {
        logic rst_i;
        logic inc_i;
        logic rst_j;
        logic inc_j;
        logic body_start;
        logic busy;
        logic done;
    } outs_t;

    function automatic outs_t decode(state_t s);
        outs_t o;
        o      = '0;
        o.busy = (s != IDLE);
        case (s)
            CLR: begin
                o.rst_i = 1'b1;
                o.rst_j = 1'b1;
            end
            INC_J:   o.inc_j = 1'b1;
            // advancing I restarts the inner loop in the same cycle
            INC_I: begin
                o.inc_i = 1'b1;
                o.rst_j = 1'b1;
            end
            BODY_GO: o.body_start = 1'b1;
            FIN:     o.done = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer
//   Down-counter giving the counter registers time to settle before their
//   z flags are sampled. Loaded while a strobe state is active, counts down
//   while enabled, expired is high at terminal count (zero).
//   Ports:
//     Clk      - system clock, rising edge
//     RSTn     - asynchronous active-low reset
//     load     - load load_val (takes priority over counting)
//     load_val - start value; expired rises load_val cycles after enabling
//     en       - count down by one per cycle while nonzero
//     expired  - counter is at zero
module settle_timer #(
    parameter int W = 2
) (
    input  logic         Clk,
    input  logic         RSTn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge Clk or negedge RSTn) begin
        if (!RSTn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/loop_seq_ctrl.sv
// loop_seq_ctrl
//   Two-level loop sequencer driving the I (outer) and J (inner) loop-counter
//   registers and handing each iteration to the execution engine.
//   Ports:
//     Clk, RSTn        - clock (rising edge), async active-low reset
//     start            - begin a loop nest (IDLE only)
//     abort            - return to IDLE at next edge, no done pulse
//     zi, zj           - z flags of I / J registers (limit < count)
//     rst_i, inc_i     - clear / increment strobes to I
//     rst_j, inc_j     - clear / increment strobes to J
//     body_start       - one-cycle pulse: run one body
//     body_done        - engine finished the body (BODY_WAIT only)
//     busy             - any state other than IDLE
//     done             - one-cycle pulse on normal completion
//     iter_cnt         - bodies issued since the last accepted start
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for start
//   CLR       | clear I and J
//   WAIT      | settle delay after a strobe, then go to the return target
//   CHK_I     | outer loop exhausted? -> FIN
//   CHK_J     | inner loop exhausted? -> INC_I
//   BODY_GO   | pulse body_start, count the iteration
//   BODY_WAIT | wait for body_done
//   INC_J     | advance inner index
//   INC_I     | advance outer index, restart inner index
//   FIN       | pulse done
module loop_seq_ctrl
    import loop_seq_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF,
    parameter int ITW    = ITW_DEF
) (
    input  logic           Clk,
    input  logic           RSTn,
    input  logic           start,
    input  logic           abort,
    input  logic           zi,
    input  logic           zj,
    output logic           rst_i,
    output logic           inc_i,
    output logic           rst_j,
    output logic           inc_j,
    output logic           body_start,
    input  logic           body_done,
    output logic           busy,
    output logic           done,
    output logic [ITW-1:0] iter_cnt
);

    // Timer is loaded during the strobe state so that WAIT lasts exactly
    // SETTLE cycles: it expires on its SETTLE-th cycle.
    localparam logic [1:0] SETTLE_LD = (SETTLE > 0) ? 2'(SETTLE - 1) : 2'd0;
    localparam bit         NO_WAIT   = (SETTLE == 0);

    state_t state, state_nxt;
    state_t ret, ret_nxt;
    outs_t  outs;
    logic   tmr_load;
    logic   tmr_exp;

    assign tmr_load = (state == CLR) || (state == INC_J) || (state == INC_I);

    settle_timer #(.W(2)) u_settle (
        .Clk      (Clk),
        .RSTn     (RSTn),
        .load     (tmr_load),
        .load_val (SETTLE_LD),
        .en       (state == WAIT),
        .expired  (tmr_exp)
    );

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret;
        if ((state != IDLE) && abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (start) state_nxt = CLR;
                CLR: begin
                    ret_nxt   = CHK_I;
                    state_nxt = NO_WAIT ? CHK_I : WAIT;
                end
                WAIT:      if (tmr_exp) state_nxt = ret;
                CHK_I:     state_nxt = zi ? FIN : CHK_J;
                CHK_J:     state_nxt = zj ? INC_I : BODY_GO;
                BODY_GO:   state_nxt = BODY_WAIT;
                BODY_WAIT: if (body_done) state_nxt = INC_J;
                INC_J: begin
                    ret_nxt   = CHK_J;
                    state_nxt = NO_WAIT ? CHK_J : WAIT;
                end
                INC_I: begin
                    ret_nxt   = CHK_I;
                    state_nxt = NO_WAIT ? CHK_I : WAIT;
                end
                FIN:       state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from the decode of the next state, so they
    // always equal decode(state) with no input-to-output path.
    always_ff @(posedge Clk or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            ret      <= CHK_I;
            outs     <= '0;
            iter_cnt <= '0;
        end else begin
            state <= state_nxt;
            ret   <= ret_nxt;
            outs  <= decode(state_nxt);
            if ((state == IDLE) && start) begin
                iter_cnt <= '0;
            end else if ((state == BODY_GO) && !abort && (iter_cnt != '1)) begin
                iter_cnt <= iter_cnt + ITW'(1);
            end
        end
    end

    assign rst_i      = outs.rst_i;
    assign inc_i      = outs.inc_i;
    assign rst_j      = outs.rst_j;
    assign inc_j      = outs.inc_j;
    assign body_start = outs.body_start;
    assign busy       = outs.busy;
    assign done       = outs.done;

endmodule

// File: tb/tb_loop_seq_ctrl.sv
// tb_loop_seq_ctrl
//   Unit 0: SETTLE=1 build. Unit 1: SETTLE=0 build.
//   Counter registers and the execution engine are modelled here; expected
//   body/done events are queued when a nest is started and popped by the
//   monitor whenever the DUT pulses body_start or done.
module tb_loop_seq_ctrl;

    logic Clk  = 1'b0;
    logic RSTn = 1'b1;
    always #5 Clk = ~Clk;

    logic [1:0] st_a  = '0;
    logic [1:0] st_b  = '0;
    logic [1:0] abort = '0;
    logic [1:0] bd_e  = '0;
    logic [1:0] bd_s  = '0;
    logic [1:0] rst_i, inc_i, rst_j, inc_j, body_start, busy, done;
    logic [1:0] zi, zj;
    logic [15:0] iter_cnt [2];

    int mi [2];
    int mj [2];
    int li [2];
    int lj [2];
    int dly [2];
    int bdc [2];
    int sc;
    bit stray_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int u;
        bit is_done;
        int i;
        int j;
        int it;
    } exp_t;
    exp_t sbq [$];

    // pulse tallies: 0 body_start, 1 inc_j, 2 inc_i, 3 rst_j, 4 rst_i, 5 done
    int cnt [2][6];
    string cnm [6] = '{"body_start", "inc_j", "inc_i", "rst_j", "rst_i", "done"};

    assign zi = {li[1] < mi[1], li[0] < mi[0]};
    assign zj = {lj[1] < mj[1], lj[0] < mj[0]};

    loop_seq_ctrl #(.SETTLE(1), .ITW(16)) dut0 (
        .Clk(Clk), .RSTn(RSTn), .start(st_a[0] | st_b[0]), .abort(abort[0]),
        .zi(zi[0]), .zj(zj[0]), .rst_i(rst_i[0]), .inc_i(inc_i[0]),
        .rst_j(rst_j[0]), .inc_j(inc_j[0]), .body_start(body_start[0]),
        .body_done(bd_e[0] | bd_s[0]), .busy(busy[0]), .done(done[0]),
        .iter_cnt(iter_cnt[0])
    );

    loop_seq_ctrl #(.SETTLE(0), .ITW(16)) dut1 (
        .Clk(Clk), .RSTn(RSTn), .start(st_a[1] | st_b[1]), .abort(abort[1]),
        .zi(zi[1]), .zj(zj[1]), .rst_i(rst_i[1]), .inc_i(inc_i[1]),
        .rst_j(rst_j[1]), .inc_j(inc_j[1]), .body_start(body_start[1]),
        .body_done(bd_e[1] | bd_s[1]), .busy(busy[1]), .done(done[1]),
        .iter_cnt(iter_cnt[1])
    );

    // loop-counter registers: sync clear, increment
    always @(posedge Clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst_i[u]) mi[u] <= 0;
            else if (inc_i[u]) mi[u] <= mi[u] + 1;
            if (rst_j[u]) mj[u] <= 0;
            else if (inc_j[u]) mj[u] <= mj[u] + 1;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
        #1;
    endtask

    // engine: body_done sampled dly cycles after the body_start cycle;
    // optional stray start/body_done in the two cycles after an inc strobe
    initial begin
        sc = 0;
        forever begin
            @(negedge Clk);
            for (int u = 0; u < 2; u++) begin
                bd_e[u] = 1'b0;
                if (bdc[u] != 0) begin
                    bdc[u]--;
                    if (bdc[u] == 0) bd_e[u] = 1'b1;
                end
                if (body_start[u]) bdc[u] = dly[u];
            end
            bd_s[0] = 1'b0;
            st_b[0] = 1'b0;
            if (sc != 0) begin
                sc--;
                bd_s[0] = 1'b1;
                st_b[0] = 1'b1;
            end
            if (stray_en && (inc_i[0] || inc_j[0])) sc = 2;
        end
    end

    // monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            for (int u = 0; u < 2; u++) begin
                if (body_start[u]) cnt[u][0]++;
                if (inc_j[u])      cnt[u][1]++;
                if (inc_i[u])      cnt[u][2]++;
                if (rst_j[u])      cnt[u][3]++;
                if (rst_i[u])      cnt[u][4]++;
                if (done[u])       cnt[u][5]++;
                if (body_start[u] || done[u]) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output unit %0d: body_start=%0b done=%0b, required none",
                                 u, body_start[u], done[u]);
                    end else begin
                        e = sbq.pop_front();
                        chk("event_unit", u, e.u);
                        chk("event_kind", {31'd0, done[u]}, {31'd0, e.is_done});
                        if (body_start[u])
                            chk("body_ij", mi[u] * 16 + mj[u], e.i * 16 + e.j);
                        chk("event_iter_cnt", iter_cnt[u], e.it);
                    end
                end
            end
        end
    end

    task automatic push_exp(int u, int l1, int l2);
        int n;
        n = 0;
        for (int i = 0; i <= l1; i++)
            for (int j = 0; j <= l2; j++) begin
                sbq.push_back('{u: u, is_done: 1'b0, i: i, j: j, it: n});
                n++;
            end
        sbq.push_back('{u: u, is_done: 1'b1, i: 0, j: 0, it: n});
        li[u] = l1;
        lj[u] = l2;
    endtask

    task automatic chk_counts(string nm, int u, int b[6], int e[6]);
        for (int k = 0; k < 6; k++)
            chk({nm, "_", cnm[k]}, cnt[u][k] - b[k], e[k]);
    endtask

    // full nest; abw asserts abort alongside start (IDLE must ignore it)
    task automatic run(int u, int l1, int l2, bit abw, int exp_lat, string nm);
        int lat;
        int b[6];
        int e[6];
        int n;
        n = (l1 + 1) * (l2 + 1);
        b = cnt[u];
        push_exp(u, l1, l2);
        abort[u] = abw;
        st_a[u]  = 1'b1;
        lat = 1;
        cyc();
        st_a[u]  = 1'b0;
        abort[u] = 1'b0;
        lat = 2;
        while (done[u] !== 1'b1 && lat < 400) begin
            cyc();
            lat++;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        cyc();
        chk({nm, "_busy_after"}, busy[u], 0);
        chk({nm, "_iter_cnt"}, iter_cnt[u], n);
        chk({nm, "_sb_empty"}, sbq.size(), 0);
        e = '{n, n, l1 + 1, l1 + 2, 1, 1};
        chk_counts(nm, u, b, e);
        sbq.delete();
    endtask

    initial begin
        int b[6];
        int e[6];
        int w;
        dly = '{2, 2};
        bdc = '{0, 0};
        #2 RSTn = 1'b0;
        repeat (3) cyc();
        chk("reset_busy", busy, 0);
        chk("reset_strobes", {rst_i, inc_i, rst_j, inc_j, body_start, done}, 0);
        chk("reset_iter_cnt0", iter_cnt[0], 0);
        chk("reset_iter_cnt1", iter_cnt[1], 0);
        RSTn = 1'b1;
        cyc();

        // baseline 2x3 nest: 4 + 2*(3*6 + 4) + 1 = 49 cycles
        run(0, 1, 2, 1'b0, 49, "base");

        // 1x1 nest, immediate body_done, abort together with start in IDLE
        dly[0] = 1;
        run(0, 0, 0, 1'b1, 14, "single");
        dly[0] = 2;

        // start / body_done pulsed outside BODY_WAIT: no change vs baseline
        stray_en = 1'b1;
        run(0, 1, 2, 1'b0, 49, "stray");
        stray_en = 1'b0;
        cyc();

        // abort in BODY_WAIT of iteration 3
        b = cnt[0];
        push_exp(0, 1, 2);
        st_a[0] = 1'b1;
        cyc();
        st_a[0] = 1'b0;
        w = 0;
        while (cnt[0][0] - b[0] < 3 && w < 300) begin
            cyc();
            w++;
        end
        chk("abort_reach_iter3", cnt[0][0] - b[0], 3);
        cyc();
        abort[0] = 1'b1;
        cyc();
        abort[0] = 1'b0;
        chk("abort_busy", busy[0], 0);
        chk("abort_iter_cnt", iter_cnt[0], 3);
        repeat (5) cyc();
        e = '{3, 2, 0, 1, 1, 0};
        chk_counts("abort", 0, b, e);
        chk("abort_iter_hold", iter_cnt[0], 3);
        sbq.delete();

        // reset while INC_I is active
        push_exp(0, 1, 2);
        st_a[0] = 1'b1;
        cyc();
        st_a[0] = 1'b0;
        w = 0;
        while (inc_i[0] !== 1'b1 && w < 300) begin
            cyc();
            w++;
        end
        chk("rstmid_reach_inc_i", inc_i[0], 1);
        RSTn = 1'b0;
        #1;
        chk("rstmid_inc_i", inc_i[0], 0);
        chk("rstmid_rst_j", rst_j[0], 0);
        chk("rstmid_busy", busy[0], 0);
        chk("rstmid_iter_cnt", iter_cnt[0], 0);
        sbq.delete();
        cyc();
        cyc();
        RSTn = 1'b1;
        cyc();
        run(0, 1, 2, 1'b0, 49, "post_reset");

        // SETTLE=0 build: 3 + 2*(3*5 + 3) + 1 = 40 cycles
        run(1, 1, 2, 1'b0, 40, "settle0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/loop_seq_ctrl.md
Name: loop_seq_ctrl

Overview:
- Two-level loop sequencer for the processor's loop-counter registers: outer index I and inner index J.
- Each counter register has sync clear, increment, bus load and a z flag. z = 1 when limit < count.
- The block drives clear/increment on both registers, samples their z flags, and hands each iteration to the execution engine via a start/done handshake.
- Limits are loaded over the bus by the control unit before start; this block never drives register bus writes.

Parameters:
- SETTLE, 1, cycles waited after a clear/increment before sampling z (0..3).
- ITW, 16, width of the iteration counter output.

Ports:
- Clk  input  1  system clock, rising edge
- RSTn  input  1  asynchronous active-low reset
- start  input  1  begin loop nest; sampled only in IDLE
- abort  input  1  terminate the sequence immediately
- zi  input  1  z flag of the I register (1 = I count exceeds I limit)
- zj  input  1  z flag of the J register
- rst_i  output  1  sync clear strobe to the I register
- inc_i  output  1  increment strobe to the I register
- rst_j  output  1  sync clear strobe to the J register
- inc_j  output  1  increment strobe to the J register
- body_start  output  1  one-cycle pulse: run one loop body
- body_done  input  1  engine finished the body; sampled only in BODY_WAIT
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the nest completes normally
- iter_cnt  output  ITW  number of bodies issued since the last accepted start

Behaviour:
- Reset (RSTn=0, async): state IDLE; all strobes, body_start, busy and done = 0; iter_cnt = 0; settle counter = 0.
- All outputs are Moore-decoded from registered state. There is no combinational input-to-output path.
- A strobe asserted in a state takes effect in the register at the edge that leaves that state.
- States and transitions:
  - IDLE: start=1 -> CLR, and iter_cnt <= 0.
  - CLR: rst_i=rst_j=1 -> WAIT (return target CHK_I).
  - WAIT: holds SETTLE cycles, then goes to the return target. SETTLE=0 bypasses WAIT entirely: the strobe state goes straight to its target.
  - CHK_I: zi=1 -> FIN; else -> CHK_J.
  - CHK_J: zj=1 -> INC_I; else -> BODY_GO.
  - BODY_GO: body_start=1; iter_cnt += 1, saturating at all-ones -> BODY_WAIT.
  - BODY_WAIT: body_done=1 -> INC_J; else stay (no timeout).
  - INC_J: inc_j=1 -> WAIT (return CHK_J).
  - INC_I: inc_i=1 and rst_j=1 in the same cycle -> WAIT (return CHK_I).
  - FIN: done=1 -> IDLE.
- Iteration count: with limits LI, LJ, the body runs exactly (LI+1)*(LJ+1) times, in order J inner, I outer.
- abort=1 in any non-IDLE state forces IDLE at the next edge:
  - abort takes priority over every other transition;
  - no done pulse is issued;
  - iter_cnt holds its value;
  - the registers are left as they are, and the next start clears them.
- start while busy: ignored. abort in IDLE: no effect.
- body_done outside BODY_WAIT: ignored, not latched.
- A body_done in the same cycle as the body_start pulse is not seen; only body_done in BODY_WAIT counts.
- Reset mid-operation: immediate IDLE. Any strobe that was asserted is removed asynchronously.

Decomposition:
- Shared package loop_seq_pkg holds:
  - the state enum: IDLE, CLR, WAIT, CHK_I, CHK_J, BODY_GO, BODY_WAIT, INC_J, INC_I, FIN;
  - the default SETTLE and ITW constants.
- One natural sub-module, settle_timer: a load/count-down with an expire flag, used by the WAIT state.
- The FSM and iter_cnt stay in the top module.

Test Plan:
- Bench models both counter registers as the team's counter-register behaviour: sync clear, increment, z = limit < count.
- Limits I=1, J=2, SETTLE=1, body_done 2 cycles after each body_start -> 6 body_start pulses, 6 inc_j, 2 inc_i, 3 rst_j, 1 rst_i, 1 done pulse, iter_cnt=6, busy low after FIN.
- Limits I=0, J=0 -> exactly 1 body_start, 1 inc_j, 1 inc_i, done; with body_done immediate, start-to-done latency is 14 cycles.
- Abort asserted in BODY_WAIT of iteration 3 (limits 1,2) -> IDLE next cycle, no done, iter_cnt=3; a later body_done causes no strobe.
- start pulsed while busy and body_done pulsed in CHK states -> no change to the sequence or counts versus the baseline run.
- RSTn dropped during INC_I -> outputs 0 without a clock edge, iter_cnt=0; a fresh start then completes a 2x3 nest normally.
- SETTLE=0 build, limits 1,2 -> same pulse counts; each check occurs the cycle after its strobe.
